// File: rtl/morse_receptor.sv
`timescale 1ns/1ps
// morse_receptor: Morse line receiver. Synchronizes the keyed line, times
// marks and gaps, classifies dots/dashes, and emits one-cycle pulses carrying
// the decoded ASCII character (or a word space) with its element pattern.
module morse_receptor #(
  parameter int UNIT_CYCLES = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       linea,
  output logic       dato_valido,
  output logic [7:0] caracter,
  output logic [4:0] patron,
  output logic [2:0] largo,
  output logic       error
);

  localparam int SAT_I = 8 * UNIT_CYCLES;
  localparam int CW    = $clog2(SAT_I + 1);

  localparam logic [CW-1:0] CNT_SAT  = CW'(SAT_I);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] DOT_MIN  = CW'(UNIT_CYCLES / 2);
  localparam logic [CW-1:0] DASH_MIN = CW'(2 * UNIT_CYCLES);
  // Gap counter holds cycles elapsed since the fall; deciding one cycle early
  // puts the registered pulse exactly 3 (or 7) units after the fall.
  localparam logic [CW-1:0] CHAR_THR = CW'(3 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] WORD_THR = CW'(7 * UNIT_CYCLES - 1);

  localparam logic [2:0] ELEM_OVF = 3'd6;
  localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;

  typedef enum logic [1:0] {REPOSO, TONO, PAUSA, PALABRA} estado_t;

  logic          sync_q, ls_q, ls_prev_q;
  logic [CW-1:0] run_q, run_d;
  logic [CW-1:0] gap_q, gap_d;
  estado_t       state_q, state_d;
  estado_t       prior_q, prior_d;
  logic [4:0]    pat_q, pat_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          dv_q, dv_d;
  logic [7:0]    car_q, car_d;
  logic [4:0]    pout_q, pout_d;
  logic [2:0]    lout_q, lout_d;
  logic          err_q, err_d;
  logic [7:0]    code;

  // International Morse lookup keyed on {element count, pattern}.
  function automatic logic [7:0] decode(input logic [2:0] n, input logic [4:0] p);
    logic [7:0] c;
    c = ASCII_UNKNOWN;
    case ({n, p})
      8'b001_00000: c = 8'h45; // E
      8'b001_00001: c = 8'h54; // T
      8'b010_00000: c = 8'h49; // I
      8'b010_00001: c = 8'h41; // A
      8'b010_00010: c = 8'h4E; // N
      8'b010_00011: c = 8'h4D; // M
      8'b011_00000: c = 8'h53; // S
      8'b011_00001: c = 8'h55; // U
      8'b011_00010: c = 8'h52; // R
      8'b011_00011: c = 8'h57; // W
      8'b011_00100: c = 8'h44; // D
      8'b011_00101: c = 8'h4B; // K
      8'b011_00110: c = 8'h47; // G
      8'b011_00111: c = 8'h4F; // O
      8'b100_00000: c = 8'h48; // H
      8'b100_00001: c = 8'h56; // V
      8'b100_00010: c = 8'h46; // F
      8'b100_00100: c = 8'h4C; // L
      8'b100_00110: c = 8'h50; // P
      8'b100_00111: c = 8'h4A; // J
      8'b100_01000: c = 8'h42; // B
      8'b100_01001: c = 8'h58; // X
      8'b100_01010: c = 8'h43; // C
      8'b100_01011: c = 8'h59; // Y
      8'b100_01100: c = 8'h5A; // Z
      8'b100_01101: c = 8'h51; // Q
      8'b101_00000: c = 8'h35; // 5
      8'b101_00001: c = 8'h34; // 4
      8'b101_00011: c = 8'h33; // 3
      8'b101_00111: c = 8'h32; // 2
      8'b101_01111: c = 8'h31; // 1
      8'b101_11111: c = 8'h30; // 0
      8'b101_10000: c = 8'h36; // 6
      8'b101_11000: c = 8'h37; // 7
      8'b101_11100: c = 8'h38; // 8
      8'b101_11110: c = 8'h39; // 9
      default:      c = ASCII_UNKNOWN;
    endcase
    return c;
  endfunction

  // An overflowed count (6) never matches, so it decodes as unknown too.
  assign code = decode(cnt_q, pat_q);

  // Two-flop synchronizer for the asynchronous line, plus a delayed copy for edge detection.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q    <= 1'b0;
      ls_q      <= 1'b0;
      ls_prev_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      sync_q    <= linea;
      ls_q      <= sync_q;
      ls_prev_q <= ls_q;
    end
  end

  // Run-length counter: length of the current constant ls run, saturating.
  always_comb begin
    if (ls_q != ls_prev_q) begin
      run_d = CNT_ONE;
    end else if (run_q == CNT_SAT) begin
      run_d = run_q;
    end else begin
      run_d = run_q + CNT_ONE;
    end
  end

  // State, counters, element buffer and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      run_q   <= '0;
      gap_q   <= '0;
      state_q <= REPOSO;
      prior_q <= REPOSO;
      pat_q   <= '0;
      cnt_q   <= '0;
      dv_q    <= 1'b0;
      car_q   <= '0;
      pout_q  <= '0;
      lout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      run_q   <= run_d;
      gap_q   <= gap_d;
      state_q <= state_d;
      prior_q <= prior_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      dv_q    <= dv_d;
      car_q   <= car_d;
      pout_q  <= pout_d;
      lout_q  <= lout_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: mark classification, gap thresholds and event emission.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    prior_d = prior_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    gap_d   = (gap_q == CNT_SAT) ? gap_q : gap_q + CNT_ONE;
    dv_d    = 1'b0;
    car_d   = car_q;
    pout_d  = pout_q;
    lout_d  = lout_q;
    err_d   = err_q;

    case (state_q)
      REPOSO: begin
        if (ls_q) begin
          state_d = TONO;
          prior_d = REPOSO;
        end
      end

      TONO: begin
        if (!ls_q) begin
          if (run_q < DOT_MIN) begin
            // Noise: restore the previous state; gap timing keeps running.
            state_d = prior_q;
          end else begin
            pat_d   = {pat_q[3:0], (run_q >= DASH_MIN)};
            cnt_d   = (cnt_q == ELEM_OVF) ? cnt_q : cnt_q + 3'd1;
            gap_d   = CNT_ONE;
            state_d = PAUSA;
          end
        end
      end

      PAUSA: begin
        if (gap_q >= CHAR_THR) begin
          // Threshold beats a mark starting this same cycle.
          dv_d    = 1'b1;
          car_d   = code;
          pout_d  = pat_q;
          lout_d  = cnt_q;
          err_d   = (code == ASCII_UNKNOWN);
          pat_d   = '0;
          cnt_d   = '0;
          state_d = ls_q ? TONO : PALABRA;
          prior_d = PALABRA;
        end else if (ls_q) begin
          state_d = TONO;
          prior_d = PAUSA;
        end
      end

      PALABRA: begin
        if (gap_q >= WORD_THR) begin
          dv_d    = 1'b1;
          car_d   = ASCII_SPACE;
          pout_d  = '0;
          lout_d  = '0;
          err_d   = 1'b0;
          state_d = ls_q ? TONO : REPOSO;
          prior_d = REPOSO;
        end else if (ls_q) begin
          state_d = TONO;
          prior_d = PALABRA;
        end
      end

      default: begin
        state_d = REPOSO;
      end
    endcase
  end

  assign dato_valido = dv_q;
  assign caracter    = car_q;
  assign patron      = pout_q;
  assign largo       = lout_q;
  assign error       = err_q;

endmodule

// File: tb/tb_morse_receptor.sv
`timescale 1ns/1ps
// tb_morse_receptor: directed line stimulus described as level/duration
// segments. A timeline model derives every expected pulse (time and fields)
// from the segment list; one compare process checks all outputs each cycle,
// and literal checks after each scenario pin the model.
module tb_morse_receptor;

  localparam int U = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic       linea;
  logic       dato_valido;
  logic [7:0] caracter;
  logic [4:0] patron;
  logic [2:0] largo;
  logic       error;

  morse_receptor #(.UNIT_CYCLES(U)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .linea      (linea),
    .dato_valido(dato_valido),
    .caracter   (caracter),
    .patron     (patron),
    .largo      (largo),
    .error      (error)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit lvl;
    int dur;
  } seg_t;

  typedef struct {
    int         t;
    logic [7:0] ch;
    logic [4:0] pat;
    logic [2:0] len;
    logic       err;
  } ev_t;

  seg_t segs[$];
  ev_t  exp_q[$];

  string alph = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
  string morse_tab [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
    "---..", "----."
  };

  // Model's view of the held output values.
  logic [7:0] m_ch  = '0;
  logic [4:0] m_pat = '0;
  logic [2:0] m_len = '0;
  logic       m_err = 1'b0;
  logic       exp_dv;
  ev_t        cur_e;

  int tests  = 0;
  int fails  = 0;
  int pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic void push_char(input int t, input string el);
    ev_t e;
    int  n;
    n     = el.len();
    e.t   = t;
    e.ch  = 8'h3F;
    e.pat = '0;
    for (int i = (n > 5 ? n - 5 : 0); i < n; i++) e.pat = {e.pat[3:0], (el[i] == 8'h2D)};
    e.len = (n > 6) ? 3'd6 : 3'(n);
    if (n <= 5)
      for (int k = 0; k < 36; k++)
        if (morse_tab[k] == el) e.ch = alph[k];
    e.err = (e.ch == 8'h3F);
    exp_q.push_back(e);
  endfunction

  function automatic void push_space(input int t);
    ev_t e;
    e.t   = t;
    e.ch  = 8'h20;
    e.pat = '0;
    e.len = '0;
    e.err = 1'b0;
    exp_q.push_back(e);
  endfunction

  task automatic add(input bit lvl, input int dur);
    seg_t s;
    s.lvl = lvl;
    s.dur = dur;
    segs.push_back(s);
  endtask

  // Appends a character as marks with one-unit gaps; the last gap is 'tail'.
  task automatic add_code(input string c, input int tail);
    for (int i = 0; i < c.len(); i++) begin
      add(1'b1, (c[i] == 8'h2D) ? 3 * U : U);
      add(1'b0, (i == c.len() - 1) ? tail : U);
    end
  endtask

  // Builds the expected event list from the segment timeline, then drives it.
  // The line reaches the receiver's timing two cycles after it is driven.
  task automatic run_scenario();
    int    n0, off, s, t_f, mode, r_cyc;
    string el;
    @(posedge CLK);
    #1;
    n0     = cyc;
    pulses = 0;
    off    = 0;
    mode   = 0;  // 0: nothing pending, 1: character pending, 2: space pending
    el     = "";
    t_f    = 0;
    foreach (segs[i]) begin
      s = n0 + off + 2;
      if (segs[i].lvl) begin
        if (mode == 1 && s >= t_f + 3 * U - 1) begin
          push_char(t_f + 3 * U, el);
          el   = "";
          mode = 2;
        end
        if (mode == 2 && s >= t_f + 7 * U - 1) begin
          push_space(t_f + 7 * U);
          mode = 0;
        end
        if (segs[i].dur >= U / 2) begin
          el   = {el, (segs[i].dur >= 2 * U) ? "-" : "."};
          t_f  = s + segs[i].dur;
          mode = 1;
        end
      end
      off += segs[i].dur;
    end
    r_cyc = n0 + off + 1;
    if (mode == 1 && t_f + 3 * U < r_cyc) begin
      push_char(t_f + 3 * U, el);
      mode = 2;
    end
    if (mode == 2 && t_f + 7 * U < r_cyc) push_space(t_f + 7 * U);

    foreach (segs[i]) begin
      linea = segs[i].lvl;
      repeat (segs[i].dur) @(posedge CLK);
      #1;
    end
    segs.delete();
  endtask

  task automatic clear_model();
    exp_q.delete();
    m_ch  = '0;
    m_pat = '0;
    m_len = '0;
    m_err = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RST   = 1'b0;
    linea = 1'b0;
    clear_model();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  // Compare process: every cycle, pulse presence and all held outputs.
  always @(negedge CLK) begin
    exp_dv = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
      cur_e  = exp_q.pop_front();
      exp_dv = 1'b1;
      m_ch   = cur_e.ch;
      m_pat  = cur_e.pat;
      m_len  = cur_e.len;
      m_err  = cur_e.err;
    end
    check("dato_valido", 32'(dato_valido), 32'(exp_dv));
    check("caracter", 32'(caracter), 32'(m_ch));
    check("patron", 32'(patron), 32'(m_pat));
    check("largo", 32'(largo), 32'(m_len));
    check("error", 32'(error), 32'(m_err));
    if (dato_valido === 1'b1) pulses++;
  end

  initial begin
    RST   = 1'b0;
    linea = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_dato_valido", 32'(dato_valido), 32'd0);
    check("rst_caracter", 32'(caracter), 32'h00);
    check("rst_largo", 32'(largo), 32'd0);
    RST = 1'b1;

    // 'E': dot then 30 low; no space since 30 < 56.
    add(1'b0, 5); add_code(".", 30);
    run_scenario();
    check("E_pulses", 32'(pulses), 32'd1);
    check("E_caracter", 32'(caracter), 32'h45);
    check("E_largo", 32'(largo), 32'd1);

    // Reset in the middle of a dash, line released low with reset.
    linea = 1'b1;
    repeat (12) @(posedge CLK);
    #1;
    RST = 1'b0;
    clear_model();
    #2;
    check("rst_async_caracter", 32'(caracter), 32'h00);
    check("rst_async_largo", 32'(largo), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST    = 1'b1;
    linea  = 1'b0;
    pulses = 0;
    repeat (60) @(posedge CLK);
    #1;
    check("rst_dash_pulses", 32'(pulses), 32'd0);
    check("rst_dash_caracter", 32'(caracter), 32'h00);

    // 'A' followed by a word gap.
    do_reset();
    add(1'b0, 5); add_code(".-", 60);
    run_scenario();
    check("A_pulses", 32'(pulses), 32'd2);
    check("A_space_caracter", 32'(caracter), 32'h20);
    check("A_space_largo", 32'(largo), 32'd0);

    // SOS with 3-unit letter gaps.
    do_reset();
    add(1'b0, 5); add_code("...", 24); add_code("---", 24); add_code("...", 30);
    run_scenario();
    check("SOS_pulses", 32'(pulses), 32'd3);
    check("SOS_caracter", 32'(caracter), 32'h53);
    check("SOS_largo", 32'(largo), 32'd3);

    // Six dots: element overflow.
    do_reset();
    add_code("......", 30);
    run_scenario();
    check("ovf_caracter", 32'(caracter), 32'h3F);
    check("ovf_error", 32'(error), 32'd1);
    check("ovf_largo", 32'(largo), 32'd6);
    check("ovf_patron", 32'(patron), 32'd0);

    // 3-cycle glitch on an idle line.
    do_reset();
    add(1'b0, 5); add(1'b1, 3); add(1'b0, 40);
    run_scenario();
    check("idle_glitch_pulses", 32'(pulses), 32'd0);

    // 3-cycle glitch 10 cycles into the gap after 'E'.
    do_reset();
    add(1'b0, 5); add(1'b1, 8); add(1'b0, 10); add(1'b1, 3); add(1'b0, 20);
    run_scenario();
    check("gap_glitch_pulses", 32'(pulses), 32'd1);
    check("gap_glitch_caracter", 32'(caracter), 32'h45);

    // Shortest dot (U/2) and shortest dash (2U).
    do_reset();
    add(1'b0, 5); add(1'b1, 4); add(1'b0, 8); add(1'b1, 16); add(1'b0, 30);
    run_scenario();
    check("min_len_caracter", 32'(caracter), 32'h41);
    check("min_len_patron", 32'(patron), 32'h01);

    // Longest dot (2U-1).
    do_reset();
    add(1'b0, 5); add(1'b1, 15); add(1'b0, 30);
    run_scenario();
    check("max_dot_caracter", 32'(caracter), 32'h45);

    // 'Q' and an unknown 4-element code.
    do_reset();
    add_code("--.-", 30);
    run_scenario();
    check("Q_caracter", 32'(caracter), 32'h51);
    check("Q_patron", 32'(patron), 32'h0D);

    do_reset();
    add_code("..--", 30);
    run_scenario();
    check("unk_caracter", 32'(caracter), 32'h3F);
    check("unk_error", 32'(error), 32'd1);
    check("unk_patron", 32'(patron), 32'h03);

    // Digit '1'.
    do_reset();
    add_code(".----", 30);
    run_scenario();
    check("one_caracter", 32'(caracter), 32'h31);
    check("one_largo", 32'(largo), 32'd5);

    // Next mark one cycle before the character threshold joins the character.
    do_reset();
    add(1'b0, 5); add(1'b1, 8); add(1'b0, 22); add(1'b1, 24); add(1'b0, 30);
    run_scenario();
    check("join_pulses", 32'(pulses), 32'd1);
    check("join_caracter", 32'(caracter), 32'h41);

    // Mark starting exactly at the threshold: 'E' emitted, then 'T'.
    do_reset();
    add(1'b0, 5); add(1'b1, 8); add(1'b0, 23); add(1'b1, 24); add(1'b0, 30);
    run_scenario();
    check("thr_pulses", 32'(pulses), 32'd2);
    check("thr_caracter", 32'(caracter), 32'h54);
    check("thr_patron", 32'(patron), 32'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
